// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage PC controller: FSM state encoding,
// redirect source indices (0 = oldest pipeline stage = highest priority)
// and the default PC width.
package fetch_pkg;

  localparam int ADDR_W_DEF = 16;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

  localparam int SRC_MEM = 0;
  localparam int SRC_ALU = 1;
  localparam int SRC_LHI = 2;
  localparam int SRC_BEQ = 3;
  localparam int SRC_JLR = 4;
  localparam int SRC_JAL = 5;

  // 16-bit saturating increment used by the optional statistics counters
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_prio_enc.sv
// Lowest-index-wins priority encoder over the redirect request vector.
// Purely combinational: sel is the winning index, any flags a request.
module fetch_prio_enc #(
  parameter int NUM_SRC = 6,
  parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] valid_i,
  output logic [SEL_W-1:0]   sel_o,
  output logic               any_o
);

  // Scan from the lowest priority upward so the lowest set index wins
  always_comb begin
    sel_o = '0;
    any_o = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        sel_o = SEL_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage program-counter controller: owns the PC, sequential
// increment, prioritised redirect selection, redirect capture across
// stalls, a registered flush pulse naming the applied source, and the
// fetch-valid qualifier.
// Optional build macro FETCH_REDIR_STATS_EN adds saturating counters of
// applied redirects (redir_count) and cycles spent holding a redirect
// (hold_cycles).
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_SRC  = 6,
  parameter int RESET_PC = 0,
  parameter int INC      = 1,
  parameter int SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [NUM_SRC-1:0]        redir_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] redir_target,
  output logic [ADDR_W-1:0]         pc_out,
  output logic [ADDR_W-1:0]         pc_inc,
  output logic                      fetch_valid,
  output logic                      flush,
`ifdef FETCH_REDIR_STATS_EN
  output logic [15:0]               redir_count,
  output logic [15:0]               hold_cycles,
`endif
  output logic [SRC_W-1:0]          flush_src
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pend_pc_q;
  logic [SRC_W-1:0]  pend_src_q;
  logic              flush_q;
  logic [SRC_W-1:0]  flush_src_q;

  logic [SRC_W-1:0]  sel;
  logic              any;
  logic [ADDR_W-1:0] sel_tgt;
  logic              take_new;
  logic              apply_d;
  logic [ADDR_W-1:0] apply_pc_d;
  logic [SRC_W-1:0]  apply_src_d;

  fetch_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SRC_W)
  ) u_prio (
    .valid_i (redir_valid),
    .sel_o   (sel),
    .any_o   (any)
  );

  assign sel_tgt = redir_target[sel*ADDR_W +: ADDR_W];
  assign pc_inc  = pc_q + ADDR_W'(INC);

  // Decide which redirect (live winner or captured one) would be applied
  always_comb begin
    take_new    = any && ((state_q == RUN) || (sel <= pend_src_q));
    apply_d     = !stall && ((state_q == HOLD) || any);
    apply_pc_d  = take_new ? sel_tgt : pend_pc_q;
    apply_src_d = take_new ? sel : pend_src_q;
  end

  // PC / redirect FSM with registered flush outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= ADDR_W'(RESET_PC);
      pend_src_q  <= '0;
      flush_q     <= 1'b0;
      flush_src_q <= '0;
    end else begin
      flush_q     <= apply_d;
      flush_src_q <= apply_d ? apply_src_d : '0;
      case (state_q)
        RUN: begin
          if (!stall) begin
            pc_q <= any ? sel_tgt : pc_inc;
          end else if (any) begin
            pend_pc_q  <= sel_tgt;
            pend_src_q <= sel;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_q    <= apply_pc_d;
            state_q <= RUN;
          end else if (take_new) begin
            pend_pc_q  <= sel_tgt;
            pend_src_q <= sel;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign pc_out      = pc_q;
  assign flush       = flush_q;
  assign flush_src   = flush_src_q;
  assign fetch_valid = (state_q == RUN) && !flush_q;

`ifdef FETCH_REDIR_STATS_EN
  logic [15:0] redir_count_q;
  logic [15:0] hold_cycles_q;

  // Saturating counters of applied redirects and cycles spent in HOLD
  always_ff @(posedge clk) begin
    if (reset) begin
      redir_count_q <= '0;
      hold_cycles_q <= '0;
    end else begin
      if (apply_d) redir_count_q <= sat_inc16(redir_count_q);
      if (state_q == HOLD) hold_cycles_q <= sat_inc16(hold_cycles_q);
    end
  end

  assign redir_count = redir_count_q;
  assign hold_cycles = hold_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with hand-computed expectations.
module tb_fetch_pc_ctrl;

  localparam int ADDR_W  = 16;
  localparam int NUM_SRC = 6;
  localparam int SRC_W   = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      stall;
  logic [NUM_SRC-1:0]        redir_valid;
  logic [NUM_SRC*ADDR_W-1:0] redir_target;
  logic [ADDR_W-1:0]         pc_out;
  logic [ADDR_W-1:0]         pc_inc;
  logic                      fetch_valid;
  logic                      flush;
  logic [SRC_W-1:0]          flush_src;
`ifdef FETCH_REDIR_STATS_EN
  logic [15:0]               redir_count;
  logic [15:0]               hold_cycles;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_pc_ctrl #(
    .ADDR_W   (ADDR_W),
    .NUM_SRC  (NUM_SRC),
    .RESET_PC (0),
    .INC      (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .pc_out       (pc_out),
    .pc_inc       (pc_inc),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
`ifdef FETCH_REDIR_STATS_EN
    .redir_count  (redir_count),
    .hold_cycles  (hold_cycles),
`endif
    .flush_src    (flush_src)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] pc, input logic fl,
                         input logic [2:0] fs, input logic fv);
    chk({tag, ".pc"}, 32'(pc_out), 32'(pc));
    chk({tag, ".flush"}, 32'(flush), 32'(fl));
    chk({tag, ".flush_src"}, 32'(flush_src), 32'(fs));
    chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(fv));
  endtask

  task automatic set_tgt(input int src, input logic [15:0] t);
    redir_target[src*ADDR_W +: ADDR_W] = t;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redir_valid = '0;
    redir_target = '0;

    // Reset
    step();
    chk_out("reset", 16'h0000, 1'b0, 3'd0, 1'b1);
`ifdef FETCH_REDIR_STATS_EN
    chk("reset.redir_count", 32'(redir_count), 32'd0);
    chk("reset.hold_cycles", 32'(hold_cycles), 32'd0);
`endif
    reset = 1'b0;

    // Sequential increment 0,1,2,3
    chk("seq.pc_inc0", 32'(pc_inc), 32'h0001);
    step(); chk_out("seq1", 16'h0001, 1'b0, 3'd0, 1'b1);
    step(); chk_out("seq2", 16'h0002, 1'b0, 3'd0, 1'b1);
    step(); chk_out("seq3", 16'h0003, 1'b0, 3'd0, 1'b1);

    // Move to 0x000F via src0, then one idle cycle to 0x0010
    redir_valid = 6'b000001; set_tgt(0, 16'h000F);
    step(); chk_out("r0", 16'h000F, 1'b1, 3'd0, 1'b0);
    redir_valid = '0;
    step(); chk_out("r0.idle", 16'h0010, 1'b0, 3'd0, 1'b1);

    // Two sources, src3 wins over src5
    redir_valid = 6'b101000; set_tgt(3, 16'h0040); set_tgt(5, 16'h0080);
    step(); chk_out("prio3", 16'h0040, 1'b1, 3'd3, 1'b0);
    redir_valid = '0;
    step(); chk_out("prio3.after", 16'h0041, 1'b0, 3'd0, 1'b1);

    // Stall captures src4; lower-priority src5 ignored; release applies src4
    stall = 1'b1; redir_valid = 6'b010000; set_tgt(4, 16'h0100);
    step(); chk_out("hold.cap", 16'h0041, 1'b0, 3'd0, 1'b0);
    redir_valid = 6'b100000; set_tgt(5, 16'h0200);
    step(); chk_out("hold.ign5", 16'h0041, 1'b0, 3'd0, 1'b0);
    stall = 1'b0; redir_valid = '0;
    step(); chk_out("hold.rel", 16'h0100, 1'b1, 3'd4, 1'b0);
    step(); chk_out("hold.after", 16'h0101, 1'b0, 3'd0, 1'b1);

    // Pending src4 overridden by src1 on the release cycle
    stall = 1'b1; redir_valid = 6'b010000; set_tgt(4, 16'h0100);
    step(); chk_out("ovr.cap", 16'h0101, 1'b0, 3'd0, 1'b0);
    stall = 1'b0; redir_valid = 6'b000010; set_tgt(1, 16'h0300);
    step(); chk_out("ovr.rel", 16'h0300, 1'b1, 3'd1, 1'b0);
    redir_valid = '0;

    // Wrap-around 0xFFFF -> 0x0000
    redir_valid = 6'b000001; set_tgt(0, 16'hFFFF);
    step(); chk_out("wrap.set", 16'hFFFF, 1'b1, 3'd0, 1'b0);
    chk("wrap.pc_inc", 32'(pc_inc), 32'h0000);
    redir_valid = '0;
    step(); chk_out("wrap", 16'h0000, 1'b0, 3'd0, 1'b1);

    // Reset while holding a pending redirect to 0x0500
    stall = 1'b1; redir_valid = 6'b000100; set_tgt(2, 16'h0500);
    step(); chk_out("rsth.cap", 16'h0000, 1'b0, 3'd0, 1'b0);
`ifdef FETCH_REDIR_STATS_EN
    chk("stats.redir_count", 32'(redir_count), 32'd5);
    chk("stats.hold_cycles", 32'(hold_cycles), 32'd3);
`endif
    reset = 1'b1; stall = 1'b0; redir_valid = '0;
    step(); chk_out("rsth.reset", 16'h0000, 1'b0, 3'd0, 1'b1);
`ifdef FETCH_REDIR_STATS_EN
    chk("rsth.redir_count", 32'(redir_count), 32'd0);
    chk("rsth.hold_cycles", 32'(hold_cycles), 32'd0);
`endif
    reset = 1'b0;
    step(); chk_out("rsth.lost", 16'h0001, 1'b0, 3'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Parametrised program-counter controller for the fetch stage.
- Owns the PC register, sequential increment and N-way prioritised redirect arbitration.
- Generalises the fixed 6-source select of the current fetch logic. Adds pending-redirect capture across stalls, a registered flush pulse identifying the winning source, and a fetch-valid qualifier.
- Sits between the pipeline-register redirect sources and the instruction memory address port.

Parameters:
ADDR_W, 16, PC/target width
NUM_SRC, 6, number of redirect sources; index 0 = highest priority (oldest stage)
RESET_PC, 0, PC value loaded on reset
INC, 1, sequential PC increment

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous active-high reset
stall  input  1  1 = hold PC (PCWrite deasserted)
redir_valid  input  NUM_SRC  per-source redirect request
redir_target  input  NUM_SRC*ADDR_W  per-source target; source i occupies bits [i*ADDR_W +: ADDR_W]
pc_out  output  ADDR_W  current fetch PC (registered)
pc_inc  output  ADDR_W  pc_out+INC, combinational, modulo 2^ADDR_W
fetch_valid  output  1  1 = instruction fetched at pc_out is on the correct path
flush  output  1  one-cycle registered pulse after a redirect is applied
flush_src  output  $clog2(NUM_SRC)  index of the applied source, valid while flush=1, else 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: pc_out=RESET_PC, state=RUN, pending cleared, flush=0, flush_src=0, fetch_valid=1. Reset overrides all other inputs in the same edge, including mid-HOLD, where the pending redirect is discarded.
- sel = lowest index i with redir_valid[i]=1; any = |redir_valid.
- State RUN:
  - !stall, any: pc<=target[sel]; next cycle flush=1, flush_src=sel.
  - !stall, !any: pc<=pc_inc.
  - stall, !any: pc holds.
  - stall, any: pc holds; pend_pc<=target[sel]; pend_src<=sel; go HOLD.
- State HOLD:
  - stall, any, sel<=pend_src: pend overwritten with target[sel]/sel. Equal index overwrites; lower priority (higher index) is ignored.
  - !stall: if any and sel<=pend_src, apply target[sel]/sel; else apply pend_pc/pend_src. Go RUN, flush pulse next cycle.
- fetch_valid = (state==RUN) & !flush. It is 0 for the cycle of the flush pulse.
- Latency: redirect request to new pc_out is 1 cycle (unstalled).
- flush is never asserted two consecutive cycles unless a new redirect is applied in the flush cycle. Back-to-back applied redirects each produce a pulse.
- Wrap-around: pc_inc wraps 2^ADDR_W-1 -> 0 silently.
- Targets of non-winning sources are don't-care.

Optional Feature:
- Macro: FETCH_REDIR_STATS_EN.
- When defined:
  - Adds output redir_count (16 bits), counting applied redirects (not HOLD captures).
  - The counter saturates at 16'hFFFF and resets to 0.
  - Adds output hold_cycles (16 bits), counting cycles in HOLD, also saturating.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {RUN, HOLD};
  - source index constants SRC_MEM=0, SRC_ALU=1, SRC_LHI=2, SRC_BEQ=3, SRC_JLR=4, SRC_JAL=5;
  - default ADDR_W.
- One sub-module, fetch_prio_enc: parametrised NUM_SRC lowest-index priority encoder producing sel and any. It is purely combinational.

Test Plan:
- Reset then 3 unstalled cycles, no redirect -> pc_out 0,1,2,3; fetch_valid=1; flush=0.
- pc=0x0010, redir_valid=6'b101000 (src3=0x0040, src5=0x0080), !stall -> next pc=0x0040; following cycle flush=1, flush_src=3, fetch_valid=0.
- stall=1 with src4=0x0100 valid, then src5=0x0200 valid while stalled, then stall=0 with no requests -> PC holds during stall, then pc=0x0100, flush_src=4.
- In HOLD (pend src4), src1=0x0300 asserted on the same cycle stall drops -> pc=0x0300, flush_src=1.
- pc=0xFFFF, INC=1, no redirect -> pc=0x0000.
- Reset asserted while in HOLD with pending 0x0500 -> pc=RESET_PC, no flush, pending lost. With FETCH_REDIR_STATS_EN, redir_count returns to 0 and saturates at 0xFFFF after 65536+ applied redirects.
